// File: rtl/turn_signal_sequencer_pkg.sv
// rtl/turn_signal_sequencer_pkg.sv - shared types, lamp patterns and decode helpers for the turn signal sequencer
package turn_signal_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S0   = 3'd4,
        ST_HON  = 3'd5,
        ST_HOFF = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_t;

    // Group patterns grow from bit 0 of each 3-bit group.
    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    function automatic mode_t decode_mode(input logic [1:0] t_signal, input logic hazard);
        if (hazard || t_signal == 2'b11) return MODE_HAZ;
        if (t_signal == 2'b10)           return MODE_LEFT;
        if (t_signal == 2'b01)           return MODE_RIGHT;
        return MODE_IDLE;
    endfunction

    function automatic state_t first_state(input mode_t mode);
        case (mode)
            MODE_LEFT, MODE_RIGHT: return ST_S1;
            MODE_HAZ:              return ST_HON;
            default:               return ST_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] state_pattern(input state_t state);
        case (state)
            ST_S1:         return PAT_1;
            ST_S2:         return PAT_2;
            ST_S3, ST_HON: return PAT_3;
            default:       return PAT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/turn_signal_sequencer_if.sv
// rtl/turn_signal_sequencer_if.sv - driver-request and lamp-drive signal bundle
interface turn_signal_sequencer_if;
    logic [1:0] t_signal;
    logic       hazard;
    logic       brake;
    logic [5:0] dir;

    modport master (output t_signal, output hazard, output brake, input dir);
    modport slave  (input t_signal, input hazard, input brake, output dir);
endinterface

// File: rtl/turn_signal_sequencer_step_timer.sv
// rtl/turn_signal_sequencer_step_timer.sv - free-running step timer with synchronous clear
module step_timer #(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/turn_signal_sequencer.sv
// rtl/turn_signal_sequencer.sv - sequential turn / hazard lamp sequencer with brake overlay
module turn_signal_sequencer
    import turn_signal_sequencer_pkg::*;
#(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    turn_signal_sequencer_if.slave  bus
);

    mode_t      mode_d, mode_q;
    state_t     state_d, state_q;
    logic       mode_chg;
    logic       step_tick;
    logic [2:0] grp, ovl;
    logic [5:0] dir_d, dir_q;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk (clk),
        .rst (rst),
        .clr (mode_chg),
        .tick(step_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_IDLE;
            dir_q   <= 6'b000000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    // A mode change beats a coincident step tick; dir is built from the next state.
    always_comb begin
        mode_d   = decode_mode(bus.t_signal, bus.hazard);
        mode_chg = (mode_d != mode_q);
        state_d  = state_q;
        if (mode_chg) begin
            state_d = first_state(mode_d);
        end else if (step_tick) begin
            case (state_q)
                ST_S1:   state_d = ST_S2;
                ST_S2:   state_d = ST_S3;
                ST_S3:   state_d = ST_S0;
                ST_S0:   state_d = ST_S1;
                ST_HON:  state_d = ST_HOFF;
                ST_HOFF: state_d = ST_HON;
                default: state_d = ST_IDLE;
            endcase
        end

        grp = state_pattern(state_d);
        ovl = bus.brake ? PAT_3 : PAT_OFF;
        case (mode_d)
            MODE_HAZ:   dir_d = {grp, grp};
            MODE_LEFT:  dir_d = {grp, ovl};
            MODE_RIGHT: dir_d = {ovl, grp};
            default:    dir_d = {ovl, ovl};
        endcase
    end

    assign bus.dir = dir_q;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// tb/tb_turn_signal_sequencer.sv - table, corner-case and randomized checks of turn_signal_sequencer
module tb_turn_signal_sequencer;

    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    turn_signal_sequencer_if bus ();

    turn_signal_sequencer #(
        .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [1:0] t_signal;
        logic       hazard;
        logic       brake;
        int         n;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t tbl [17];

    // reference model state: decoded mode (0 idle,1 left,2 right,3 haz) and cycles since mode start
    int m_prev = 0;
    int m_k    = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: dir=%b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [1:0] t, input logic h, input logic b);
        rst          = r;
        bus.t_signal = t;
        bus.hazard   = h;
        bus.brake    = b;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int model_mode(input logic [1:0] t, input logic h);
        if (h || t == 2'b11) return 3;
        if (t == 2'b10) return 1;
        if (t == 2'b01) return 2;
        return 0;
    endfunction

    function automatic logic [5:0] model_dir(input int m, input int k, input logic b);
        logic [2:0] lit;
        logic [2:0] ovl;
        int step;
        step = (k / STEP) % 4;
        case (step)
            0:       lit = 3'b001;
            1:       lit = 3'b011;
            2:       lit = 3'b111;
            default: lit = 3'b000;
        endcase
        ovl = b ? 3'b111 : 3'b000;
        case (m)
            3:       return (((k / STEP) % 2) == 0) ? 6'b111111 : 6'b000000;
            1:       return {lit, ovl};
            2:       return {ovl, lit};
            default: return {ovl, ovl};
        endcase
    endfunction

    initial begin
        logic [1:0] t;
        logic       h, b, r;
        logic [5:0] exp;
        int         m;

        apply(1'b1, 2'b00, 1'b0, 1'b0);

        tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b1, 2, 6'b000000, "reset_brake"};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1, 6'b001000, "left_s1"};
        tbl[2]  = '{1'b0, 2'b10, 1'b0, 1'b0, 4, 6'b011000, "left_s2"};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 1'b0, 4, 6'b111000, "left_s3"};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 1'b0, 4, 6'b000000, "left_s0"};
        tbl[5]  = '{1'b0, 2'b10, 1'b0, 1'b0, 4, 6'b001000, "left_wrap"};
        tbl[6]  = '{1'b0, 2'b01, 1'b0, 1'b1, 1, 6'b111001, "right_brk_s1"};
        tbl[7]  = '{1'b0, 2'b01, 1'b0, 1'b1, 4, 6'b111011, "right_brk_s2"};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 1'b1, 4, 6'b111111, "right_brk_s3"};
        tbl[9]  = '{1'b0, 2'b01, 1'b0, 1'b1, 4, 6'b111000, "right_brk_s0"};
        tbl[10] = '{1'b0, 2'b10, 1'b1, 1'b1, 1, 6'b111111, "haz_on"};
        tbl[11] = '{1'b0, 2'b10, 1'b1, 1'b1, 4, 6'b000000, "haz_off"};
        tbl[12] = '{1'b0, 2'b10, 1'b1, 1'b1, 4, 6'b111111, "haz_on_again"};
        tbl[13] = '{1'b0, 2'b10, 1'b1, 1'b0, 1, 6'b111111, "haz_brake_drop"};
        tbl[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 1, 6'b000000, "idle"};
        tbl[15] = '{1'b0, 2'b00, 1'b0, 1'b1, 1, 6'b111111, "idle_brake_rise"};
        tbl[16] = '{1'b0, 2'b00, 1'b0, 1'b0, 1, 6'b000000, "idle_brake_fall"};

        #1;
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].rst, tbl[i].t_signal, tbl[i].hazard, tbl[i].brake);
            edges(tbl[i].n);
            check(tbl[i].name, bus.dir, tbl[i].exp);
        end

        // mode switch on the exact cycle the step tick fires
        apply(1'b1, 2'b00, 1'b0, 1'b0);
        edges(1);
        apply(1'b0, 2'b10, 1'b0, 1'b0);
        edges(1);
        edges(11);
        check("left_s3_before_switch", bus.dir, 6'b111000);
        apply(1'b0, 2'b01, 1'b0, 1'b0);
        edges(1);
        check("switch_on_tick", bus.dir, 6'b000001);
        edges(3);
        check("timer_restart_hold", bus.dir, 6'b000001);
        edges(1);
        check("timer_restart_adv", bus.dir, 6'b000011);

        // one-cycle reset during hazard on
        apply(1'b0, 2'b00, 1'b1, 1'b0);
        edges(1);
        check("haz_before_rst", bus.dir, 6'b111111);
        apply(1'b1, 2'b00, 1'b1, 1'b1);
        edges(1);
        check("haz_rst_pulse", bus.dir, 6'b000000);
        apply(1'b0, 2'b00, 1'b1, 1'b0);
        edges(1);
        check("haz_after_rst", bus.dir, 6'b111111);
        edges(4);
        check("haz_after_rst_off", bus.dir, 6'b000000);

        // randomized run against the reference model
        apply(1'b1, 2'b00, 1'b0, 1'b0);
        edges(1);
        m_prev = 0;
        m_k    = 0;
        t = 2'b00; h = 1'b0; b = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                t = 2'($urandom_range(3));
                h = ($urandom_range(4) == 0);
            end
            if ($urandom_range(5) == 0) b = ~b;
            r = ($urandom_range(149) == 0);
            apply(r, t, h, b);
            edges(1);
            if (r) begin
                m_prev = 0;
                m_k    = 0;
                exp    = 6'b000000;
            end else begin
                m = model_mode(t, h);
                if (m != m_prev) m_k = 0;
                else             m_k++;
                m_prev = m;
                exp = model_dir(m, m_k, b);
            end
            check("random", bus.dir, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
